ht_cmd_arbiter: RTL
===================

Name: ht_cmd_arbiter

Overview:
- Shares one hash-table pipeline (calc_hash -> head_table -> data_table) between NUM_REQ independent command requesters.
- Arbitrates round-robin and drives one registered command stream into the table's ht_cmd input.
- Records the requester ID of each issued command in an in-order tag FIFO.
- Routes each returning ht_res result back to the requester that issued it.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- MAX_OUTSTANDING, 8, tag FIFO depth = maximum commands in flight inside the table (power of 2).
- REQ_W, $clog2(NUM_REQ), requester-ID width (derived, not overridable).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_cmd_i  in  NUM_REQ x ht_command_t  per-requester command
- req_valid_i  in  NUM_REQ  per-requester command valid
- req_ready_o  out  NUM_REQ  per-requester command accepted (one-hot or zero)
- ht_cmd_o  out  ht_command_t  command to hash table
- ht_cmd_valid_o  out  1  command valid
- ht_cmd_ready_i  in  1  hash table accepts command
- ht_res_i  in  ht_result_t  result from hash table
- ht_res_valid_i  in  1  result valid
- ht_res_ready_o  out  1  result accepted
- req_res_o  out  NUM_REQ x ht_result_t  per-requester result (broadcast of ht_res_i)
- req_res_valid_o  out  NUM_REQ  per-requester result valid (one-hot or zero)
- req_res_ready_i  in  NUM_REQ  per-requester result ready
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  commands in flight
- proto_err_o  out  1  sticky: result arrived with tag FIFO empty

Behaviour:
- Reset values: ht_cmd_valid_o=0, ht_cmd_o='0, rr pointer=0, FIFO empty, outstanding_o=0, proto_err_o=0, all req_ready_o=0, all req_res_valid_o=0.
- Output stage:
  - One register holding ht_cmd_o/ht_cmd_valid_o.
  - Loadable when ht_cmd_valid_o==0 or ht_cmd_ready_i==1 (load and drain in the same cycle allowed).
  - ht_cmd_o is held stable while valid and not ready.
- Arbitration:
  - Performed when the stage is loadable AND outstanding_o < MAX_OUTSTANDING.
  - Search req_valid_i starting at the rr pointer, upward with wrap; the first set bit wins.
  - req_ready_o[winner]=1 that cycle only; req_cmd_i[winner] is loaded; the tag FIFO pushes the winner ID.
  - rr pointer <= winner+1 mod NUM_REQ. Pointer is unchanged when there is no grant.
- Latency: request accepted in cycle N -> ht_cmd_valid_o in cycle N+1.
- Requesters hold valid/cmd until ready (standard valid/ready). A deasserted valid is never granted.
- Full: outstanding_o==MAX_OUTSTANDING blocks all grants, even if a pop occurs in the same cycle. This avoids a combinational path from ht_res_valid_i to req_ready_o.
- Result routing (combinational, zero latency):
  - tag = FIFO head.
  - req_res_valid_o[tag] = ht_res_valid_i & !empty.
  - ht_res_ready_o = req_res_ready_i[tag] & !empty.
  - Pop on ht_res_valid_i & ht_res_ready_o.
- Empty FIFO with ht_res_valid_i=1:
  - ht_res_ready_o=1; the result is dropped (no req_res_valid_o).
  - proto_err_o <= 1, cleared only by reset.
- outstanding_o:
  - +1 on push, -1 on pop, unchanged on simultaneous push and pop.
  - Never exceeds MAX_OUTSTANDING and never wraps below 0.
- FIFO pointers wrap modulo MAX_OUTSTANDING. Full/empty are derived from outstanding_o.
- Reset mid-operation: all in-flight tags and the output-stage command are discarded. The hash table is reset by the same rst_i, so no stale results return.

Optional Feature:
- Macro: HT_ARB_STATS_EN.
- With the macro defined:
  - Adds per-requester 32-bit counters, exposed on output stat_grant_cnt_o (NUM_REQ x 32) and output stat_stall_cnt_o (NUM_REQ x 32).
  - Grant counter: increments on req_ready_o[i].
  - Stall counter: increments each cycle req_valid_i[i] & !req_ready_o[i].
  - Counters saturate at 2^32-1 and reset to 0.
- Without the macro: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- hash_table package:
  - ht_command_t and ht_result_t (existing).
  - New constant HT_ARB_MAX_REQ=16.
  - New typedef ht_req_id_t (logic [3:0]).
- Sub-module ht_tag_fifo: synchronous FIFO of ht_req_id_t, parameter DEPTH, with push/pop/head/count. Reused for any future in-order return path.
- Round-robin search stays inline.

Test Plan:
- NUM_REQ=4, requesters 0..3 all valid continuously, ht_cmd_ready_i=1 -> grant order 0,1,2,3,0,1...; ht_cmd_valid_o one cycle after each grant.
- Only requester 2 valid, then requester 1 also valid while 2 is held -> 2 granted first, pointer=3, next grant goes to 1 via wrap.
- ht_cmd_ready_i=0 for 5 cycles with a pending command -> ht_cmd_o stable, no req_ready_o pulses, outstanding_o unchanged.
- MAX_OUTSTANDING=8, 8 commands issued, no results -> outstanding_o=8, all req_ready_o=0. One result returns to the head tag -> next cycle grants resume.
- Results returned in order for tags {3,0,0,2}, with req_res_ready_i[0]=0 for 3 cycles -> ht_res_ready_o=0 during the stall, each result appears only on the matching req_res_valid_o, outstanding_o ends at 0.
- ht_res_valid_i=1 with FIFO empty -> ht_res_ready_o=1, no req_res_valid_o, proto_err_o=1 persisting until rst_i.

Source files
------------

// File: rtl/ht_cmd_arbiter_pkg.sv
// Shared hash-table types: command/result words plus the requester-ID type
// used by the command arbiter and its in-order tag FIFO.
// Imported by every file of the arbiter slice.
package hash_table;

  typedef enum logic [1:0] {
    HT_OP_SEARCH = 2'd0,
    HT_OP_INSERT = 2'd1,
    HT_OP_DELETE = 2'd2,
    HT_OP_NOP    = 2'd3
  } ht_opcode_t;

  typedef struct packed {
    ht_opcode_t  op;
    logic [31:0] key;
    logic [31:0] val;
  } ht_command_t;

  typedef struct packed {
    logic        found;
    logic [31:0] val;
  } ht_result_t;

  // Largest requester count the arbiter supports; sizes the stored tag.
  localparam int HT_ARB_MAX_REQ = 16;

  typedef logic [$clog2(HT_ARB_MAX_REQ)-1:0] ht_req_id_t;

endpackage

// File: rtl/ht_cmd_arbiter_if.sv
// Bundle of requester-side and table-side signals of the command arbiter.
// master = arbiter view, slave = requesters + hash table view.
// Signal names keep their arbiter-relative _i/_o suffixes in both views.
interface ht_cmd_arbiter_if #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 8
);
  import hash_table::*;

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  ht_command_t [NUM_REQ-1:0] req_cmd_i;
  logic        [NUM_REQ-1:0] req_valid_i;
  logic        [NUM_REQ-1:0] req_ready_o;
  ht_command_t               ht_cmd_o;
  logic                      ht_cmd_valid_o;
  logic                      ht_cmd_ready_i;
  ht_result_t                ht_res_i;
  logic                      ht_res_valid_i;
  logic                      ht_res_ready_o;
  ht_result_t  [NUM_REQ-1:0] req_res_o;
  logic        [NUM_REQ-1:0] req_res_valid_o;
  logic        [NUM_REQ-1:0] req_res_ready_i;
  logic        [CNT_W-1:0]   outstanding_o;
  logic                      proto_err_o;

  modport master (
    input  req_cmd_i, req_valid_i, ht_cmd_ready_i, ht_res_i, ht_res_valid_i, req_res_ready_i,
    output req_ready_o, ht_cmd_o, ht_cmd_valid_o, ht_res_ready_o, req_res_o, req_res_valid_o,
           outstanding_o, proto_err_o
  );

  modport slave (
    output req_cmd_i, req_valid_i, ht_cmd_ready_i, ht_res_i, ht_res_valid_i, req_res_ready_i,
    input  req_ready_o, ht_cmd_o, ht_cmd_valid_o, ht_res_ready_o, req_res_o, req_res_valid_o,
           outstanding_o, proto_err_o
  );

endinterface

// File: rtl/ht_cmd_arbiter_tag_fifo.sv
// Purpose: in-order FIFO of requester IDs (ht_tag_fifo), DEPTH a power of 2.
// Latency: push visible at head_o the cycle after; head_o is a direct read of storage.
// Backpressure: push ignored when full, pop ignored when empty; caller must gate.
module ht_tag_fifo
  import hash_table::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  ht_req_id_t       push_dat_i,
  input  logic             pop_i,
  output ht_req_id_t       head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  ht_req_id_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next-state: write at tail, advance pointers (natural power-of-2 wrap), track occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the FIFO and discards stored tags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ht_cmd_arbiter.sv
// Purpose: round-robin share of one hash-table command port among NUM_REQ requesters, results routed back by in-order tag.
// Latency: grant in cycle N -> ht_cmd_valid_o in N+1; result routing is combinational (zero cycles).
// Backpressure: grants stall while the output register is held or MAX_OUTSTANDING are in flight; HT_ARB_STATS_EN adds grant/stall counters.
module ht_cmd_arbiter
  import hash_table::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  ht_cmd_arbiter_if.master         bus
`ifdef HT_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][31:0] stat_grant_cnt_o,
  output logic [NUM_REQ-1:0][31:0] stat_stall_cnt_o
`endif
);

  localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [REQ_W-1:0]   rr_q, rr_d;
  logic               cmd_vld_q, cmd_vld_d;
  ht_command_t        cmd_q, cmd_d;
  logic               proto_err_q, proto_err_d;

  logic               load_en, grant, gnt_vld;
  logic [REQ_W-1:0]   gnt_id, cand;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ-1:0] res_vld;
  logic               tag_rdy;
  logic               fifo_pop, fifo_empty, fifo_full;
  ht_req_id_t         head_tag;
  logic [CNT_W-1:0]   fifo_count;

  // Output register may take a new command when empty or draining this cycle.
  // Full is judged on the registered count only, so a same-cycle pop never
  // opens a grant; this keeps ht_res_valid_i off the req_ready_o path.
  assign load_en = !cmd_vld_q || bus.ht_cmd_ready_i;
  assign grant   = load_en && !fifo_full && gnt_vld && !rst_i;

  // Round-robin search: first valid requester at or above rr_q, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = REQ_W'((int'(rr_q) + i) % NUM_REQ);
      if (!gnt_vld && bus.req_valid_i[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  // One-hot ready to the winner only in the granting cycle.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant && (gnt_id == REQ_W'(i));
    end
  end

  // Next-state for pointer, output register and sticky protocol error.
  always_comb begin
    rr_d        = rr_q;
    cmd_vld_d   = cmd_vld_q;
    cmd_d       = cmd_q;
    proto_err_d = proto_err_q || (bus.ht_res_valid_i && fifo_empty);
    if (grant) begin
      rr_d      = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + REQ_W'(1);
      cmd_vld_d = 1'b1;
      cmd_d     = bus.req_cmd_i[gnt_id];
    end else if (bus.ht_cmd_ready_i) begin
      cmd_vld_d = 1'b0;
    end
  end

  // Steer the returning result to the requester recorded at the FIFO head.
  always_comb begin
    res_vld = '0;
    tag_rdy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (head_tag == ht_req_id_t'(i)) begin
        res_vld[i] = bus.ht_res_valid_i && !fifo_empty;
        tag_rdy    = bus.req_res_ready_i[i];
      end
    end
  end

  // An orphan result (no tag in flight) is swallowed so the table never hangs.
  assign bus.ht_res_ready_o  = fifo_empty || tag_rdy;
  assign fifo_pop            = bus.ht_res_valid_i && tag_rdy && !fifo_empty;
  assign bus.req_res_valid_o = res_vld;
  assign bus.req_res_o       = {NUM_REQ{bus.ht_res_i}};
  assign bus.req_ready_o     = req_ready;
  assign bus.ht_cmd_o        = cmd_q;
  assign bus.ht_cmd_valid_o  = cmd_vld_q;
  assign bus.outstanding_o   = fifo_count;
  assign bus.proto_err_o     = proto_err_q;

  ht_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (grant),
    .push_dat_i (ht_req_id_t'(gnt_id)),
    .pop_i      (fifo_pop),
    .head_o     (head_tag),
    .count_o    (fifo_count),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  // Control and output-stage registers; reset drops any held command.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q        <= '0;
      cmd_vld_q   <= 1'b0;
      cmd_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      cmd_vld_q   <= cmd_vld_d;
      cmd_q       <= cmd_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef HT_ARB_STATS_EN
  logic [NUM_REQ-1:0][31:0] grant_cnt_q, grant_cnt_d;
  logic [NUM_REQ-1:0][31:0] stall_cnt_q, stall_cnt_d;

  // Saturating per-requester grant and stall counters.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    stall_cnt_d = stall_cnt_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i] && (grant_cnt_q[i] != '1)) begin
        grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
      end
      if (bus.req_valid_i[i] && !req_ready[i] && (stall_cnt_q[i] != '1)) begin
        stall_cnt_d[i] = stall_cnt_q[i] + 32'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_grant_cnt_o = grant_cnt_q;
  assign stat_stall_cnt_o = stall_cnt_q;
`endif

endmodule
